// File: rtl/arb_mux.sv
// arb_mux: N-channel packet-aware mux with direct/round-robin select and a single registered output stage.
module arb_mux #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  localparam int SELW = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [SELW-1:0] lockChan, ptr, rrGrant, grant, idx;
  logic loadEn, xfer;
  logic [WIDTH-1:0] selData;
  always_comb begin
    rrGrant = ptr;
    idx = ptr;
    // walk downward so the last hit is the nearest channel after ptr
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = ptr + SELW'(i);
      rrGrant = in_valid[idx] ? idx : rrGrant;
    end
  end
  assign grant = (state == LOCKED) ? lockChan : mode ? rrGrant : sel;
  assign loadEn = !out_valid || out_ready;
  assign xfer = !rst && loadEn && in_valid[grant];
  assign in_ready = xfer ? (CHANNELS'(1) << grant) : '0;
  assign selData = in_data[grant*WIDTH +: WIDTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_last <= 1'b0;
      out_chan <= '0;
      out_valid <= 1'b0;
      state <= IDLE;
      lockChan <= '0;
      ptr <= SELW'(CHANNELS - 1);
    end else if (xfer) begin
      out_data <= selData;
      out_last <= in_last[grant];
      out_chan <= grant;
      out_valid <= 1'b1;
      if (in_last[grant]) begin
        state <= IDLE;
        ptr <= grant;
      end else begin
        state <= LOCKED;
        lockChan <= grant;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed checks of arb_mux at default parameters and at WIDTH=16, CHANNELS=8.
module tb_arb_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, mode, outReady, outValid, outLast;
  logic [1:0] sel, outChan;
  logic [31:0] inData;
  logic [3:0] inValid, inLast, inReady;
  logic [7:0] outData;
  logic rstB, modeB, outReadyB, outValidB, outLastB;
  logic [2:0] selB, outChanB;
  logic [127:0] inDataB;
  logic [7:0] inValidB, inLastB, inReadyB;
  logic [15:0] outDataB;
  int checks = 0;
  int errors = 0;

  arb_mux dutA (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(inData), .in_valid(inValid),
    .in_last(inLast), .in_ready(inReady), .out_data(outData), .out_last(outLast),
    .out_chan(outChan), .out_valid(outValid), .out_ready(outReady)
  );
  arb_mux #(.WIDTH(16), .CHANNELS(8)) dutB (
    .clk(clk), .rst(rstB), .mode(modeB), .sel(selB), .in_data(inDataB), .in_valid(inValidB),
    .in_last(inLastB), .in_ready(inReadyB), .out_data(outDataB), .out_last(outLastB),
    .out_chan(outChanB), .out_valid(outValidB), .out_ready(outReadyB)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b1; sel = 2'd0; outReady = 1'b1;
    inData = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; inValid = 4'hf; inLast = 4'hf;
    rstB = 1'b1; modeB = 1'b1; selB = 3'd0; outReadyB = 1'b1; inValidB = 8'hff; inLastB = 8'hff;
    for (int c = 0; c < 8; c++) inDataB[c*16 +: 16] = 16'hB000 + 16'(c);
    #12;
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_data", 32'(outData), 32'd0);
    chk("rst_chan", 32'(outChan), 32'd0);
    chk("rst_ready", 32'(inReady), 32'h0);
    rst = 1'b0;
    #1;
    chk("rr_first_ready", 32'(inReady), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rr_chan", 32'(outChan), 32'(i % 4));
      chk("rr_data", 32'(outData), 32'hA0 + 32'(i % 4));
      chk("rr_valid", 32'(outValid), 32'd1);
    end
    // asynchronous reset between edges with a beat buffered
    inValid = 4'h0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(outValid), 32'd0);
    chk("arst_chan", 32'(outChan), 32'd0);
    inValid = 4'hf;
    #1;
    chk("arst_ready", 32'(inReady), 32'h0);
    rst = 1'b0;
    #1;
    chk("arst_ptr", 32'(inReady), 32'h1);
    inValid = 4'b0010; inLast = 4'b0010; inData[15:8] = 8'h99;
    tick;
    chk("pre_lock_chan", 32'(outChan), 32'd1);
    inValid = 4'b0110; inLast = 4'b0010; inData[23:16] = 8'h11; inData[15:8] = 8'h44;
    #1;
    chk("lock_grant", 32'(inReady), 32'b0100);
    tick;
    chk("lock_d0", 32'(outData), 32'h11);
    chk("lock_c0", 32'(outChan), 32'd2);
    inData[23:16] = 8'h22;
    #1;
    chk("lock_hold", 32'(inReady), 32'b0100);
    tick;
    chk("lock_d1", 32'(outData), 32'h22);
    chk("lock_c1", 32'(outChan), 32'd2);
    inValid = 4'b0010;
    #1;
    chk("lock_gap_ready", 32'(inReady), 32'h0);
    tick;
    chk("lock_gap_valid", 32'(outValid), 32'd0);
    inValid = 4'b0110; inLast = 4'b0110; inData[23:16] = 8'h33;
    tick;
    chk("lock_d2", 32'(outData), 32'h33);
    chk("lock_c2", 32'(outChan), 32'd2);
    chk("lock_last", 32'(outLast), 32'd1);
    tick;
    chk("after_lock_d", 32'(outData), 32'h44);
    chk("after_lock_c", 32'(outChan), 32'd1);
    mode = 1'b0; sel = 2'd3; inValid = 4'b0111; inLast = 4'hf;
    #1;
    chk("dir_ready", 32'(inReady), 32'h0);
    tick;
    chk("dir_novalid", 32'(outValid), 32'd0);
    inValid = 4'b1111; inData[31:24] = 8'h5C;
    tick;
    chk("dir_data", 32'(outData), 32'h5C);
    chk("dir_chan", 32'(outChan), 32'd3);
    outReady = 1'b0; inValid = 4'b1000; inData[31:24] = 8'h77;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready", 32'(inReady), 32'h0);
      tick;
      chk("bp_data", 32'(outData), 32'h5C);
      chk("bp_valid", 32'(outValid), 32'd1);
    end
    outReady = 1'b1;
    #1;
    chk("bp_release_ready", 32'(inReady), 32'b1000);
    tick;
    chk("bp_new_data", 32'(outData), 32'h77);
    chk("bp_new_valid", 32'(outValid), 32'd1);
    chk("bp_new_chan", 32'(outChan), 32'd3);
    rstB = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("sweep_chan", 32'(outChanB), 32'(i % 8));
      chk("sweep_data", 32'(outDataB), 32'hB000 + 32'(i % 8));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
